// File: rtl/branch_resolver_pkg.sv
// ----------------------------------------------------------------------------
// branch_resolver_pkg
// Shared definitions for the execute-stage branch resolver and its queue.
//   BR_PC_W          width of the PC/target fields held in a queue entry
//   BR_OPCODE_CLASS  branch opcode[5:2] class, shared with the predictor
//   PC_STEP          sequential instruction step used for not-taken redirects
//   br_state_e       resolver FSM state
//   br_entry_t       one recorded prediction {taken, pc, target}
// ----------------------------------------------------------------------------
package branch_resolver_pkg;

   localparam int         BR_PC_W         = 32;
   localparam logic [3:0] BR_OPCODE_CLASS = 4'b0111;
   localparam int         PC_STEP         = 4;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } br_state_e;

   typedef struct packed {
      logic               taken;
      logic [BR_PC_W-1:0] pc;
      logic [BR_PC_W-1:0] target;
   } br_entry_t;

endpackage

// File: rtl/branch_queue.sv
// ----------------------------------------------------------------------------
// branch_queue
// In-order FIFO of predicted branches awaiting resolution.
//   clk, rst_n     clock, asynchronous active-low reset
//   i_push         write i_wr_entry at the tail (caller guarantees not full)
//   i_pop          drop the head (caller guarantees not empty)
//   i_clear        empty the queue; dominates push and pop
//   o_head         oldest entry
//   o_count        occupancy, o_full / o_empty derived from it
// DEPTH must be a power of 2 so the pointers wrap by natural overflow.
// ----------------------------------------------------------------------------
module branch_queue
   import branch_resolver_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_clear,
   input  br_entry_t     i_wr_entry,
   output br_entry_t     o_head,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   br_entry_t     r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: nothing is read before it has been written.
   always_ff @(posedge clk) begin
      if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_wr_entry;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/branch_resolver.sv
// ----------------------------------------------------------------------------
// branch_resolver
// Execute-stage partner of the 2-bit predictor. Records predicted branches,
// resolves the oldest against the actual outcome, flushes and redirects on a
// mispredict, and returns a training update to the predictor.
//   clk, reset            clock, asynchronous active-low reset
//   pred_valid/taken/pc/target, pred_ready   prediction push from fetch
//   res_valid/taken/target                   actual outcome from execute
//   mispredict, redirect_pc, flush           recovery outputs (registered)
//   upd_valid, upd_taken, upd_pc             predictor training (registered)
//   outstanding        queue occupancy
//   mispredict_count   saturating mispredict counter
//   queue_error        sticky: resolution seen with an empty queue
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_RUN   | accepting pushes and resolutions
//   ST_FLUSH | flush held for FLUSH_CYCLES cycles; pushes and resolutions
//            | are ignored
//
// PC_W is the width of the package entry fields (BR_PC_W).
// ----------------------------------------------------------------------------
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter  int PC_W         = BR_PC_W,
   parameter  int DEPTH        = 4,
   parameter  int FLUSH_CYCLES = 2,
   localparam int CW           = $clog2(DEPTH + 1),
   localparam int FCW          = $clog2(FLUSH_CYCLES + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pred_valid,
   input  logic            pred_taken,
   input  logic [PC_W-1:0] pred_pc,
   input  logic [PC_W-1:0] pred_target,
   output logic            pred_ready,
   input  logic            res_valid,
   input  logic            res_taken,
   input  logic [PC_W-1:0] res_target,
   output logic            mispredict,
   output logic [PC_W-1:0] redirect_pc,
   output logic            flush,
   output logic            upd_valid,
   output logic            upd_taken,
   output logic [PC_W-1:0] upd_pc,
   output logic [CW-1:0]   outstanding,
   output logic [15:0]     mispredict_count,
   output logic            queue_error
);

   br_state_e       r_state;
   logic [FCW-1:0]  r_flush_cnt;
   logic            r_flush;
   logic            r_mispredict;
   logic [PC_W-1:0] r_redirect_pc;
   logic            r_upd_valid;
   logic            r_upd_taken;
   logic [PC_W-1:0] r_upd_pc;
   logic [15:0]     r_misp_cnt;
   logic            r_queue_error;

   br_entry_t       w_wr_entry;
   br_entry_t       w_head;
   logic [CW-1:0]   w_count;
   logic            w_full;
   logic            w_empty;
   logic            w_run;
   logic            w_push;
   logic            w_res_run;
   logic            w_pop;
   logic            w_err;
   logic            w_misp;
   logic [PC_W-1:0] w_next_pc;

   assign w_run      = (r_state == ST_RUN);
   // Ready looks only at registered state; a same-cycle pop does not free a slot.
   assign pred_ready = w_run && !w_full;
   assign w_push     = pred_valid && pred_ready;
   assign w_res_run  = res_valid && w_run;
   assign w_pop      = w_res_run && !w_empty;
   assign w_err      = w_res_run && w_empty;

   // A taken branch is also wrong if it went somewhere other than predicted.
   assign w_misp    = w_pop && ((res_taken != w_head.taken) ||
                                (res_taken && (res_target != w_head.target)));
   assign w_next_pc = res_taken ? res_target : (w_head.pc + PC_W'(PC_STEP));

   assign w_wr_entry = '{taken: pred_taken, pc: pred_pc, target: pred_target};

   // A mispredict discards every younger entry, including a same-cycle push.
   branch_queue #(
      .DEPTH      (DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst_n      (reset),
      .i_push     (w_push),
      .i_pop      (w_pop),
      .i_clear    (w_misp),
      .i_wr_entry (w_wr_entry),
      .o_head     (w_head),
      .o_count    (w_count),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_RUN;
         r_flush_cnt   <= '0;
         r_flush       <= 1'b0;
         r_mispredict  <= 1'b0;
         r_redirect_pc <= '0;
         r_upd_valid   <= 1'b0;
         r_upd_taken   <= 1'b0;
         r_upd_pc      <= '0;
         r_misp_cnt    <= '0;
         r_queue_error <= 1'b0;
      end else begin
         r_mispredict <= w_misp;
         r_upd_valid  <= w_pop;
         if (w_pop) begin
            r_upd_taken <= res_taken;
            r_upd_pc    <= w_head.pc;
         end
         if (w_err) r_queue_error <= 1'b1;

         case (r_state)
            ST_RUN: begin
               if (w_misp) begin
                  r_state       <= ST_FLUSH;
                  r_flush       <= 1'b1;
                  r_flush_cnt   <= FCW'(FLUSH_CYCLES - 1);
                  r_redirect_pc <= w_next_pc;
                  if (r_misp_cnt != 16'hFFFF) r_misp_cnt <= r_misp_cnt + 16'd1;
               end
            end
            ST_FLUSH: begin
               if (r_flush_cnt == '0) begin
                  r_state <= ST_RUN;
                  r_flush <= 1'b0;
               end else begin
                  r_flush_cnt <= r_flush_cnt - FCW'(1);
               end
            end
            default: begin
               r_state <= ST_RUN;
               r_flush <= 1'b0;
            end
         endcase
      end
   end

   assign mispredict       = r_mispredict;
   assign redirect_pc      = r_redirect_pc;
   assign flush            = r_flush;
   assign upd_valid        = r_upd_valid;
   assign upd_taken        = r_upd_taken;
   assign upd_pc           = r_upd_pc;
   assign outstanding      = w_count;
   assign mispredict_count = r_misp_cnt;
   assign queue_error      = r_queue_error;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

   localparam int PC_W         = 32;
   localparam int DEPTH        = 4;
   localparam int FLUSH_CYCLES = 2;
   localparam int CW           = $clog2(DEPTH + 1);

   logic            clk;
   logic            reset;
   logic            pred_valid;
   logic            pred_taken;
   logic [PC_W-1:0] pred_pc;
   logic [PC_W-1:0] pred_target;
   logic            pred_ready;
   logic            res_valid;
   logic            res_taken;
   logic [PC_W-1:0] res_target;
   logic            mispredict;
   logic [PC_W-1:0] redirect_pc;
   logic            flush;
   logic            upd_valid;
   logic            upd_taken;
   logic [PC_W-1:0] upd_pc;
   logic [CW-1:0]   outstanding;
   logic [15:0]     mispredict_count;
   logic            queue_error;

   branch_resolver #(
      .PC_W             (PC_W),
      .DEPTH            (DEPTH),
      .FLUSH_CYCLES     (FLUSH_CYCLES)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .pred_valid       (pred_valid),
      .pred_taken       (pred_taken),
      .pred_pc          (pred_pc),
      .pred_target      (pred_target),
      .pred_ready       (pred_ready),
      .res_valid        (res_valid),
      .res_taken        (res_taken),
      .res_target       (res_target),
      .mispredict       (mispredict),
      .redirect_pc      (redirect_pc),
      .flush            (flush),
      .upd_valid        (upd_valid),
      .upd_taken        (upd_taken),
      .upd_pc           (upd_pc),
      .outstanding      (outstanding),
      .mispredict_count (mispredict_count),
      .queue_error      (queue_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct {
      logic        taken;
      logic [31:0] pc;
      logic [31:0] target;
   } ent_t;

   ent_t        mq[$];
   int          m_flush_left;
   logic        m_misp;
   logic        m_flush;
   logic        m_upd_valid;
   logic        m_upd_taken;
   logic        m_err;
   logic [31:0] m_redirect;
   logic [31:0] m_upd_pc;
   logic [15:0] m_cnt;

   int n_checks = 0;
   int n_errors = 0;

   task automatic model_reset();
      mq.delete();
      m_flush_left = 0;
      m_misp       = 1'b0;
      m_flush      = 1'b0;
      m_upd_valid  = 1'b0;
      m_upd_taken  = 1'b0;
      m_err        = 1'b0;
      m_redirect   = '0;
      m_upd_pc     = '0;
      m_cnt        = '0;
   endtask

   function automatic logic model_ready();
      return (m_flush_left == 0) && (mq.size() < DEPTH);
   endfunction

   // Advance the model by one clock edge given the inputs applied before it.
   task automatic model_step(input logic pv, input logic pt, input logic [31:0] ppc,
                             input logic [31:0] ptgt, input logic rv, input logic rt,
                             input logic [31:0] rtgt);
      logic ready;
      logic mis;
      ent_t h;
      ent_t e;
      ready       = model_ready();
      mis         = 1'b0;
      m_misp      = 1'b0;
      m_upd_valid = 1'b0;
      if (m_flush_left > 0) begin
         m_flush_left--;
         m_flush = (m_flush_left > 0);
      end else begin
         m_flush = 1'b0;
         if (rv) begin
            if (mq.size() == 0) begin
               m_err = 1'b1;
            end else begin
               h = mq.pop_front();
               m_upd_valid = 1'b1;
               m_upd_taken = rt;
               m_upd_pc    = h.pc;
               mis = (rt != h.taken) || (rt && (rtgt != h.target));
               if (mis) begin
                  mq.delete();
                  m_misp       = 1'b1;
                  m_redirect   = rt ? rtgt : h.pc + 32'd4;
                  if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                  m_flush_left = FLUSH_CYCLES;
                  m_flush      = 1'b1;
               end
            end
         end
         if (pv && ready && !mis) begin
            e.taken  = pt;
            e.pc     = ppc;
            e.target = ptgt;
            mq.push_back(e);
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("mispredict",       32'(mispredict),       32'(m_misp));
      chk("redirect_pc",      redirect_pc,           m_redirect);
      chk("flush",            32'(flush),            32'(m_flush));
      chk("upd_valid",        32'(upd_valid),        32'(m_upd_valid));
      chk("upd_taken",        32'(upd_taken),        32'(m_upd_taken));
      chk("upd_pc",           upd_pc,                m_upd_pc);
      chk("outstanding",      32'(outstanding),      32'(mq.size()));
      chk("mispredict_count", 32'(mispredict_count), 32'(m_cnt));
      chk("queue_error",      32'(queue_error),      32'(m_err));
   endtask

   // Called at a falling edge: apply inputs, check ready, clock, check outputs.
   task automatic step(input logic pv, input logic pt, input logic [31:0] ppc,
                       input logic [31:0] ptgt, input logic rv, input logic rt,
                       input logic [31:0] rtgt);
      pred_valid  = pv;
      pred_taken  = pt;
      pred_pc     = ppc;
      pred_target = ptgt;
      res_valid   = rv;
      res_taken   = rt;
      res_target  = rtgt;
      #1;
      chk("pred_ready", 32'(pred_ready), 32'(model_ready()));
      model_step(pv, pt, ppc, ptgt, rv, rt, rtgt);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic push(input logic pt, input logic [31:0] ppc, input logic [31:0] ptgt);
      step(1'b1, pt, ppc, ptgt, 1'b0, 1'b0, '0);
   endtask

   task automatic resolve(input logic rt, input logic [31:0] rtgt);
      step(1'b0, 1'b0, '0, '0, 1'b1, rt, rtgt);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] tg [2];
      logic        pv, rv, rt;
      logic [31:0] rtgt;
      tg[0] = 32'h80;
      tg[1] = 32'h90;

      reset       = 1'b0;
      pred_valid  = 1'b0;
      pred_taken  = 1'b0;
      pred_pc     = '0;
      pred_target = '0;
      res_valid   = 1'b0;
      res_taken   = 1'b0;
      res_target  = '0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Reset then idle
      idle();
      idle();
      chk("lit_reset_ready",  32'(pred_ready),       32'd1);
      chk("lit_reset_out",    32'(outstanding),      32'd0);
      chk("lit_reset_misp",   32'(mispredict),       32'd0);
      chk("lit_reset_flush",  32'(flush),            32'd0);
      chk("lit_reset_upd",    32'(upd_valid),        32'd0);
      chk("lit_reset_cnt",    32'(mispredict_count), 32'd0);
      chk("lit_reset_qerr",   32'(queue_error),      32'd0);
      chk("lit_reset_redir",  redirect_pc,           32'd0);

      // Correct not-taken prediction
      push(1'b0, 32'h100, 32'h200);
      resolve(1'b0, 32'h0);
      chk("lit_nt_upd_valid", 32'(upd_valid),   32'd1);
      chk("lit_nt_upd_pc",    upd_pc,           32'h100);
      chk("lit_nt_upd_taken", 32'(upd_taken),   32'd0);
      chk("lit_nt_misp",      32'(mispredict),  32'd0);
      chk("lit_nt_out",       32'(outstanding), 32'd0);

      // Direction mispredict; pushes during flush are refused
      push(1'b0, 32'h100, 32'h200);
      push(1'b1, 32'h108, 32'h300);
      resolve(1'b1, 32'h200);
      chk("lit_dir_misp",  32'(mispredict),       32'd1);
      chk("lit_dir_redir", redirect_pc,           32'h200);
      chk("lit_dir_flush", 32'(flush),            32'd1);
      chk("lit_dir_out",   32'(outstanding),      32'd0);
      chk("lit_dir_cnt",   32'(mispredict_count), 32'd1);
      push(1'b0, 32'h10C, 32'h400);
      chk("lit_dir_flush2", 32'(flush),       32'd1);
      chk("lit_dir_nopush", 32'(outstanding), 32'd0);
      push(1'b0, 32'h110, 32'h400);
      chk("lit_dir_flush_end", 32'(flush),       32'd0);
      chk("lit_dir_nopush2",   32'(outstanding), 32'd0);

      // Target mispredict, then not-taken redirect
      push(1'b1, 32'h40, 32'h80);
      resolve(1'b1, 32'h90);
      chk("lit_tgt_redir", redirect_pc, 32'h90);
      idle();
      idle();
      push(1'b1, 32'h40, 32'h80);
      resolve(1'b0, 32'h0);
      chk("lit_nt_redir", redirect_pc, 32'h44);
      chk("lit_nt_cnt",   32'(mispredict_count), 32'd3);
      idle();
      idle();

      // Full and pointer wrap
      for (int i = 0; i < 4; i++) push(1'b0, 32'h1000 + 32'(4 * i), 32'h2000);
      chk("lit_full_out", 32'(outstanding), 32'd4);
      chk("lit_full_rdy", 32'(pred_ready),  32'd0);
      push(1'b0, 32'h1FFC, 32'h2000);
      chk("lit_full_drop", 32'(outstanding), 32'd4);
      resolve(1'b0, 32'h0);
      chk("lit_wrap_pc0", upd_pc, 32'h1000);
      step(1'b1, 1'b0, 32'h1010, 32'h2000, 1'b1, 1'b0, 32'h0);
      chk("lit_wrap_pc1", upd_pc,           32'h1004);
      chk("lit_pushpop_out", 32'(outstanding), 32'd3);
      push(1'b0, 32'h1014, 32'h2000);
      for (int i = 0; i < 4; i++) begin
         resolve(1'b0, 32'h0);
         chk("lit_wrap_order", upd_pc, 32'h1008 + 32'(4 * i));
      end
      chk("lit_wrap_empty", 32'(outstanding), 32'd0);

      // Resolution on an empty queue
      resolve(1'b0, 32'h0);
      chk("lit_qerr",     32'(queue_error), 32'd1);
      chk("lit_qerr_upd", 32'(upd_valid),   32'd0);
      idle();
      idle();
      chk("lit_qerr_hold", 32'(queue_error), 32'd1);

      // Saturation: preload the counter near its ceiling rather than spending
      // ~260k cycles on 65533 real mispredicts.
      force dut.r_misp_cnt = 16'hFFFC;
      #1;
      release dut.r_misp_cnt;
      m_cnt = 16'hFFFC;
      for (int i = 0; i < 6; i++) begin
         push(1'b0, 32'h700, 32'h800);
         resolve(1'b1, 32'h800);
         idle();
         idle();
      end
      chk("lit_sat", 32'(mispredict_count), 32'hFFFF);

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         pv = ($urandom_range(0, 9) < 6);
         rv = ($urandom_range(0, 9) < 5);
         if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
            rt   = mq[0].taken;
            rtgt = mq[0].target;
         end else begin
            rt   = 1'($urandom_range(0, 1));
            rtgt = tg[$urandom_range(0, 1)];
         end
         step(pv, 1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00},
              tg[$urandom_range(0, 1)], rv, rt, rtgt);
      end

      // Reset asserted during a flush
      idle();
      idle();
      idle();
      if (mq.size() == 0) push(1'b1, 32'h500, 32'h600);
      resolve(!mq[0].taken, 32'h600);
      chk("lit_mid_flush", 32'(flush), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("lit_rst_flush", 32'(flush),            32'd0);
      chk("lit_rst_misp",  32'(mispredict),       32'd0);
      chk("lit_rst_upd",   32'(upd_valid),        32'd0);
      chk("lit_rst_cnt",   32'(mispredict_count), 32'd0);
      chk("lit_rst_qerr",  32'(queue_error),      32'd0);
      chk("lit_rst_out",   32'(outstanding),      32'd0);
      chk("lit_rst_redir", redirect_pc,           32'd0);
      chk("lit_rst_rdy",   32'(pred_ready),       32'd1);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      idle();
      push(1'b1, 32'h900, 32'hA00);
      resolve(1'b1, 32'hA00);
      chk("lit_post_rst_pc", upd_pc, 32'h900);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Execute-stage counterpart to the 2-bit branch predictor.
- Records each branch the fetch stage issued with a prediction.
- When execute supplies the actual outcome, it resolves the oldest recorded branch, detects a misprediction, and issues a flush plus a redirect PC.
- Returns a training update (outcome, PC) to the predictor.

Parameters:
- PC_W, 32, PC/target width in bits.
- DEPTH, 4, in-flight branch queue entries; must be a power of 2, minimum 2.
- FLUSH_CYCLES, 2, cycles the flush output is held after a mispredict; minimum 1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pred_valid  in  1  fetch issues a predicted branch this cycle.
- pred_taken  in  1  predictor's direction (predictor state bit 1).
- pred_pc  in  PC_W  branch instruction PC.
- pred_target  in  PC_W  target fetched if predicted taken.
- pred_ready  out  1  push is accepted this cycle.
- res_valid  in  1  execute resolves the oldest outstanding branch.
- res_taken  in  1  actual outcome (PC mux select).
- res_target  in  PC_W  actual branch target.
- mispredict  out  1  one-cycle pulse.
- redirect_pc  out  PC_W  correct next PC; valid while mispredict=1.
- flush  out  1  squash younger pipeline stages.
- upd_valid  out  1  one-cycle pulse, predictor training strobe.
- upd_taken  out  1  actual outcome for training.
- upd_pc  out  PC_W  PC of the resolved branch.
- outstanding  out  $clog2(DEPTH+1)  current queue occupancy.
- mispredict_count  out  16  saturating mispredict counter.
- queue_error  out  1  sticky flag: resolution arrived while the queue was empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - Queue empty; pointers 0; state RUN.
  - mispredict, flush, upd_valid, upd_taken, queue_error = 0.
  - redirect_pc, upd_pc = 0; mispredict_count = 0; outstanding = 0.
- Reset asserted mid-flush or mid-operation: all of the above apply immediately; no pending pulse survives reset.
- FSM states: RUN and FLUSH.
  - RUN to FLUSH: a resolution mispredicts.
  - FLUSH to RUN: after FLUSH_CYCLES cycles with flush=1; a down-counter loaded with FLUSH_CYCLES-1.
- pred_ready = (state==RUN) && (outstanding < DEPTH).
  - Combinational from registered state only.
  - Does not account for a same-cycle pop.
- Push: pred_valid && pred_ready writes {pred_taken, pred_pc, pred_target} at the write pointer. Write pointer wraps modulo DEPTH.
- Pop: res_valid in RUN with the queue non-empty pops the head.
  - Mispredict condition: (res_taken != head.taken) || (res_taken && res_target != head.target).
  - Correct next PC: res_taken ? res_target : head.pc + 4 (mod 2^PC_W).
- Latency: all resolution outputs are registered and appear the cycle after res_valid.
  - upd_valid=1 on every pop, with upd_taken=res_taken and upd_pc=head.pc.
  - mispredict=1 and redirect_pc=correct next PC on a mispredicting pop only.
  - flush rises in the same cycle as mispredict.
- On a mispredicting pop:
  - The entire queue is cleared; all younger entries are wrong-path.
  - Any same-cycle push is dropped.
  - mispredict_count increments, saturating at 16'hFFFF.
- Simultaneous push and correct pop in RUN: both occur; occupancy is unchanged.
- In FLUSH:
  - pred_valid is ignored (pred_ready=0).
  - res_valid is ignored: no pop, no update, no error.
- res_valid in RUN with the queue empty:
  - queue_error set and held until reset.
  - No upd_valid, no mispredict.
- Between pulses: redirect_pc and upd_pc hold their last values.

Decomposition:
- Shared package holds:
  - Resolver state enum {RUN, FLUSH}.
  - Constant BR_OPCODE_CLASS = 4'b0111, the branch opcode[5:2] class shared with the predictor.
  - Constant PC_STEP = 4.
  - Queue entry struct {taken, pc, target}.
- One sub-module, branch_queue:
  - Parameterised DEPTH/PC_W FIFO with push, pop, and clear (clear dominates push).
  - Exposes head entry, count, full, empty.
- Resolver FSM, compare logic, and counter stay in branch_resolver.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset=0 three cycles, release, drive no pred_valid/res_valid for 2 cycles.
  - Required: all outputs 0, pred_ready=1, outstanding=0.
- Correct not-taken prediction:
  - Stimulus: push {0, 0x100, 0x200}, then res_valid with res_taken=0.
  - Required next cycle: upd_valid=1, upd_pc=0x100, upd_taken=0, mispredict=0, outstanding=0.
- Direction mispredict:
  - Stimulus: push {0, 0x100, 0x200} and {1, 0x108, 0x300}, then resolve the first with res_taken=1, res_target=0x200.
  - Required: mispredict=1, redirect_pc=0x200, flush=1 for 2 cycles, outstanding=0, mispredict_count=1.
  - Required: pred_valid during the flush cycles is not accepted.
- Target mispredict and not-taken redirect:
  - Stimulus A: push {1, 0x40, 0x80}, resolve taken with res_target=0x90.
  - Required A: redirect_pc=0x90.
  - Stimulus B: push {1, 0x40, 0x80}, resolve not-taken.
  - Required B: redirect_pc=0x44.
- Full and wrap:
  - Stimulus: push 4 entries; pred_valid on cycle 5.
  - Required: pred_ready=0, entry not accepted.
  - Stimulus: pop 1 correct, push 2 more, resolve all correctly.
  - Required: upd_pc in exact push order across the pointer wrap.
- Error and saturation:
  - Stimulus: res_valid on an empty queue.
  - Required: queue_error=1 and stays set; no upd_valid.
  - Stimulus: force 65536 mispredicts.
  - Required: mispredict_count=16'hFFFF and holds.
